// File: rtl/ddr_weight_writer.sv
// AXI4 write master: buffers the host DMA weight stream in a small FIFO and writes it to
// DDR as INCR bursts from an aligned base address, reporting busy/done/error upstream.
module ddr_weight_writer #(
  parameter int unsigned C_M_AXI_ID_WIDTH   = 4,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
  parameter int unsigned DMA_ADDR_WIDTH     = 27,
  parameter int unsigned BURST_LEN          = 16,
  parameter int unsigned FIFO_DEPTH         = 32
) (
  input  logic                              clk,
  input  logic                              m_axi_aresetn,
  input  logic                              load_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     ddr_base_addr,
  input  logic [DMA_ADDR_WIDTH-1:0]         ddr_write_length,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     ddr_din,
  input  logic                              ddr_din_en,
  output logic                              ddr_din_rdy,
  input  logic                              ddr_din_eop,
  output logic                              load_busy,
  output logic                              load_done,
  output logic                              load_err,
  output logic [C_M_AXI_ID_WIDTH-1:0]       m_axi_awid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                        m_axi_awlen,
  output logic [2:0]                        m_axi_awsize,
  output logic [1:0]                        m_axi_awburst,
  output logic [3:0]                        m_axi_awcache,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wlast,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [C_M_AXI_ID_WIDTH-1:0]       m_axi_arid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                        m_axi_arlen,
  output logic [2:0]                        m_axi_arsize,
  output logic [1:0]                        m_axi_arburst,
  output logic [3:0]                        m_axi_arcache,
  output logic                              m_axi_arvalid,
  output logic                              m_axi_rready
);

  localparam int unsigned BytesPerBeat = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned BeatShift    = $clog2(BytesPerBeat);
  localparam int unsigned AlignBits    = $clog2(BURST_LEN * BytesPerBeat);
  localparam int unsigned PtrW         = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW         = PtrW + 1;
  localparam int unsigned BeatW        = $clog2(BURST_LEN) + 1;
  localparam int unsigned AddrW        = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned LenW         = DMA_ADDR_WIDTH;

  typedef enum logic [2:0] {StIdle, StFill, StAw, StW, StB, StDone} state_e;

  state_e            state_q, state_d;
  logic [AddrW-1:0]  awaddr_q, awaddr_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [LenW-1:0]   acc_q, acc_d;
  logic [LenW-1:0]   rem_q, rem_d;
  logic [BeatW-1:0]  beats_q, beats_d;
  logic [BeatW-1:0]  wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [C_M_AXI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic             fifo_full, fifo_empty, push, pop, wvalid, wlast, busy, din_rdy;
  logic [BeatW-1:0] beats_fill;
  logic [AddrW-1:0] align_mask;

  assign busy       = (state_q != StIdle);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // Ready depends only on registered state, never on the AXI side.
  assign din_rdy    = busy & ~fifo_full & (acc_q < len_q);
  assign push       = ddr_din_en & din_rdy;
  assign wvalid     = (state_q == StW) & ~fifo_empty;
  assign pop        = wvalid & m_axi_wready;
  assign wlast      = (wcnt_q == beats_q - BeatW'(1));
  assign align_mask = {AddrW{1'b1}} << AlignBits;

  always_comb begin
    if (rem_q >= LenW'(BURST_LEN)) beats_fill = BeatW'(BURST_LEN);
    else                           beats_fill = BeatW'(rem_q);
  end

  always_comb begin
    state_d  = state_q;
    awaddr_d = awaddr_q;
    len_d    = len_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    beats_d  = beats_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          awaddr_d = ddr_base_addr & align_mask;
          len_d    = ddr_write_length;
          rem_d    = ddr_write_length;
          acc_d    = '0;
          err_d    = 1'b0;
          state_d  = (ddr_write_length == '0) ? StDone : StFill;
        end
      end
      StFill: begin
        // Issue AW only once the whole burst is buffered so W never starves mid-burst.
        if (32'(count_q) >= 32'(beats_fill)) begin
          beats_d = beats_fill;
          state_d = StAw;
        end
      end
      StAw: begin
        if (m_axi_awready) begin
          awaddr_d = awaddr_q + (AddrW'(beats_q) << BeatShift);
          rem_d    = rem_q - LenW'(beats_q);
          wcnt_d   = '0;
          state_d  = StW;
        end
      end
      StW: begin
        if (pop) begin
          if (wlast) state_d = StB;
          else       wcnt_d  = wcnt_q + BeatW'(1);
        end
      end
      StB: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) err_d = 1'b1;
          state_d = (rem_q != '0) ? StFill : StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (push) begin
      acc_d = acc_q + LenW'(1);
      // EOP must coincide exactly with the final beat; mismatch either way is an error.
      if (ddr_din_eop != (acc_q == len_q - LenW'(1))) err_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q  <= StIdle;
      awaddr_q <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      beats_q  <= '0;
      wcnt_q   <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      awaddr_q <= awaddr_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      beats_q  <= beats_d;
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ddr_din;
  end

  assign ddr_din_rdy   = din_rdy;
  assign load_busy     = busy;
  assign load_done     = (state_q == StDone);
  assign load_err      = err_q;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = 8'(beats_q - BeatW'(1));
  assign m_axi_awsize  = 3'(BeatShift);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'b0010;
  assign m_axi_awvalid = (state_q == StAw);
  assign m_axi_wdata   = mem_q[rd_ptr_q];
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wlast;
  assign m_axi_wvalid  = wvalid;
  assign m_axi_bready  = 1'b1;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = '0;
  assign m_axi_arlen   = '0;
  assign m_axi_arsize  = 3'(BeatShift);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arcache = 4'b0010;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;

endmodule

// File: tb/tb_ddr_weight_writer.sv
// Directed bench for ddr_weight_writer: scoreboarded AW/W traffic, B responder, reset recovery.
module tb_ddr_weight_writer;

  localparam int FD = 32;

  typedef struct {logic [511:0] data; logic eop;} beat_t;
  typedef struct {logic [511:0] data; logic last;} wexp_t;
  typedef struct {logic [31:0] addr; logic [7:0] len;} awexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, load_start;
  logic [31:0]  ddr_base_addr;
  logic [26:0]  ddr_write_length;
  logic [511:0] ddr_din;
  logic         ddr_din_en, ddr_din_rdy, ddr_din_eop;
  logic         load_busy, load_done, load_err;
  logic [3:0]   awid, arid;
  logic [31:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize;
  logic [1:0]   awburst, arburst, bresp;
  logic [3:0]   awcache, arcache;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready, arvalid, rready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;

  ddr_weight_writer dut (
    .clk(clk), .m_axi_aresetn(rst_n), .load_start(load_start),
    .ddr_base_addr(ddr_base_addr), .ddr_write_length(ddr_write_length),
    .ddr_din(ddr_din), .ddr_din_en(ddr_din_en), .ddr_din_rdy(ddr_din_rdy),
    .ddr_din_eop(ddr_din_eop), .load_busy(load_busy), .load_done(load_done),
    .load_err(load_err), .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awcache(awcache),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arcache(arcache), .m_axi_arvalid(arvalid),
    .m_axi_rready(rready)
  );

  int checks = 0, failures = 0;
  beat_t  stream_q[$];
  wexp_t  exp_w[$];
  awexp_t exp_aw[$];
  logic [1:0] bresp_q[$];
  int   occ = 0, bursts_left = 0, w_seen = 0;
  logic push_hs = 0, b_pending = 0, b_chk = 0, b_last = 0;
  logic gaps = 0, rnd = 0, hold_w = 0, exp_err = 0;
  logic aw_stall = 0, w_stall = 0;
  logic [31:0]  stall_addr;
  logic [7:0]   stall_len;
  logic [511:0] stall_data;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream source: holds each beat until the DUT accepts it.
  initial begin
    ddr_din_en = 0; ddr_din = '0; ddr_din_eop = 0;
    forever begin
      @(posedge clk);
      if (push_hs && stream_q.size() > 0) void'(stream_q.pop_front());
      push_hs = 0;
      #1;
      if (stream_q.size() > 0 && !(gaps && $urandom_range(2) == 0)) begin
        ddr_din_en = 1; ddr_din = stream_q[0].data; ddr_din_eop = stream_q[0].eop;
      end else begin
        ddr_din_en = 0;
      end
    end
  end

  // AXI slave side: ready generation and single B response per burst.
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      awready = rnd ? 1'($urandom_range(1)) : 1'b1;
      wready  = hold_w ? 1'b0 : (rnd ? 1'($urandom_range(1)) : 1'b1);
      if (bvalid) begin
        bvalid = 0; b_chk = 1;
      end else if (b_pending) begin
        bvalid = 1;
        bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
        b_last = (bursts_left == 1);
        bursts_left--;
        b_pending = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      awexp_t ea;
      wexp_t  ew;
      logic   w_hs;
      if (b_chk) begin chk("done_after_b", load_done, b_last); b_chk = 0; end
      if (occ == FD) chk("rdy_low_when_full", ddr_din_rdy, 0);
      if (aw_stall) begin
        chk("aw_stall_valid", awvalid, 1);
        chk("aw_stall_addr", awaddr, stall_addr);
        chk("aw_stall_len", awlen, stall_len);
      end
      if (w_stall) begin
        chk("w_stall_valid", wvalid, 1);
        chk("w_stall_data", wdata, stall_data);
      end
      aw_stall = awvalid && !awready;
      stall_addr = awaddr; stall_len = awlen;
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", awaddr, 'x);
        else begin
          ea = exp_aw.pop_front();
          chk("aw_addr", awaddr, ea.addr);
          chk("aw_len", awlen, ea.len);
          chk("aw_size_burst_cache", {awsize, awburst, awcache}, {3'b110, 2'b01, 4'b0010});
        end
      end
      w_stall = wvalid && !wready;
      stall_data = wdata;
      w_hs = wvalid && wready;
      if (w_hs) begin
        if (exp_w.size() == 0) chk("w_unexpected", wdata, 'x);
        else begin
          ew = exp_w.pop_front();
          chk("w_data", wdata, ew.data);
          chk("w_last", wlast, ew.last);
        end
        w_seen++;
        if (wlast) b_pending = 1;
      end
      push_hs = ddr_din_en && ddr_din_rdy;
      occ = occ + int'(push_hs) - int'(w_hs);
    end
  end

  task automatic start_xfer(input logic [31:0] base, input int len, input int eop_pos,
                            input int bad);
    logic [31:0]  addr;
    logic [511:0] d;
    int rem, b, gi, nb;
    addr = base & ~32'h3FF; rem = len; gi = 0; nb = 0;
    while (rem > 0) begin
      b = (rem > 16) ? 16 : rem;
      exp_aw.push_back('{addr, 8'(b - 1)});
      for (int i = 0; i < b; i++) begin
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        stream_q.push_back('{d, (gi == eop_pos)});
        exp_w.push_back('{d, (i == b - 1)});
        gi++;
      end
      bresp_q.push_back((nb == bad) ? 2'b10 : 2'b00);
      addr += 32'(b * 64); rem -= b; nb++;
    end
    bursts_left = nb;
    w_seen = 0;
    exp_err = ((len != 0) && (eop_pos != len - 1)) || (bad >= 0);
    @(posedge clk); #1;
    load_start = 1; ddr_base_addr = base; ddr_write_length = 27'(len);
    @(posedge clk); #1;
    load_start = 0; ddr_base_addr = 32'hDEAD_BEEF; ddr_write_length = 27'd5;
  endtask

  task automatic finish_xfer(input int len);
    int cyc;
    logic got;
    cyc = 0; got = 0;
    while (cyc < 4000 && !got) begin @(negedge clk); cyc++; got = load_done; end
    chk("done_seen", got, 1);
    if (got) begin
      chk("err_at_done", load_err, exp_err);
      if (len == 0) chk("len0_done_latency", (cyc <= 2), 1);
      @(negedge clk);
      chk("done_one_cycle", load_done, 0);
      chk("idle_after_done", load_busy, 0);
    end
    chk("aw_all_issued", 32'(exp_aw.size()), 0);
    chk("w_all_written", 32'(exp_w.size()), 0);
  endtask

  task automatic run(input logic [31:0] base, input int len, input int eop_pos,
                     input int bad, input logic g, input logic r);
    gaps = g; rnd = r;
    start_xfer(base, len, eop_pos, bad);
    finish_xfer(len);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 0; load_start = 0; ddr_base_addr = '0; ddr_write_length = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_outputs", {awvalid, wvalid, load_busy, load_done, load_err, ddr_din_rdy},
        6'b0);
    chk("rst_awaddr", awaddr, 0);
    rst_n = 1;
    @(negedge clk);
    chk("tied_channels", {bready, arvalid, rready}, 3'b100);
    chk("idle_not_busy", load_busy, 0);

    run(32'h1000, 4, 3, -1, 0, 0);
    run(32'h0, 40, 39, -1, 0, 0);
    run(32'h0001_2345, 20, 19, -1, 1, 1);
    run(32'h800, 40, 39, 1, 0, 0);
    run(32'h3000, 4, 3, -1, 0, 0);
    run(32'h4000, 4, 2, -1, 0, 0);
    run(32'h5000, 0, -1, -1, 0, 0);

    // Backpressure W until the FIFO fills, then release.
    hold_w = 1;
    gaps = 0; rnd = 0;
    start_xfer(32'h8000, 40, 39, -1);
    cyc = 0;
    while (occ < FD && cyc < 500) begin @(posedge clk); cyc++; end
    chk("fifo_reached_full", 32'(occ), FD);
    repeat (4) begin @(negedge clk); chk("rdy_full_hold", ddr_din_rdy, 0); end
    hold_w = 0;
    finish_xfer(40);

    // Reset mid-way through burst 2, after an early EOP has raised load_err.
    start_xfer(32'h0, 40, 5, -1);
    cyc = 0;
    while (w_seen < 18 && cyc < 500) begin @(posedge clk); cyc++; end
    chk("reached_burst2", (w_seen >= 18), 1);
    chk("err_before_reset", load_err, 1);
    @(posedge clk); #3;
    rst_n = 0;
    stream_q.delete(); exp_w.delete(); exp_aw.delete(); bresp_q.delete();
    b_pending = 0; b_chk = 0; bvalid = 0; push_hs = 0; occ = 0; bursts_left = 0;
    aw_stall = 0; w_stall = 0;
    #1;
    chk("midrst_outputs", {awvalid, wvalid, load_busy, load_done, load_err, ddr_din_rdy},
        6'b0);
    chk("midrst_awaddr", awaddr, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    run(32'h2000, 1, 0, -1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
